// File: rtl/hwpe_ctrl_package.sv
// Shared definitions for the HWPE control slice: context scheduler codes,
// engine sequencing states and the ring-pointer wrap helper.
package hwpe_ctrl_package;

  localparam int CXT_RESP_ANOTHER_PE_OFFLOADING = -2;
  localparam int CXT_RESP_ALL_CXT_BUSY          = -1;
  localparam int unsigned CXT_RESP_W            = 32;

  typedef enum logic [1:0] {
    CXT_IDLE,
    CXT_START,
    CXT_RUN,
    CXT_DONE
  } cxt_sched_state_t;

  typedef struct packed {
    logic                  valid;
    logic [CXT_RESP_W-1:0] data;
  } cxt_resp_t;

  // Next index on a ring of n slots; n == 1 always yields 0.
  function automatic int unsigned cxt_wrap_inc(input int unsigned ptr, input int unsigned n);
    return ((ptr + 1) >= n) ? 0 : (ptr + 1);
  endfunction

endpackage

// File: rtl/hwpe_ctrl_cxt_ring_ptr.sv
// Modulo-N wrapping context pointer with increment and synchronous clear.
module hwpe_ctrl_cxt_ring_ptr
  import hwpe_ctrl_package::*;
#(
  parameter int unsigned N = 2,
  parameter int unsigned W = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear_i,
  input  logic         inc_i,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clear_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = W'(cxt_wrap_inc(32'(ptr_q), N));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/hwpe_ctrl_cxt_sched.sv
// Context scheduler: offload lock arbitration, context ring occupancy and
// engine start/done sequencing for the HWPE control register file.
module hwpe_ctrl_cxt_sched
  import hwpe_ctrl_package::*;
#(
  parameter  int unsigned N_CONTEXT   = 2,
  parameter  int unsigned ID_WIDTH    = 16,
  localparam int unsigned LOG_CONTEXT = (N_CONTEXT > 1) ? $clog2(N_CONTEXT) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic                   acquire_i,
  input  logic                   trigger_i,
  input  logic [ID_WIDTH-1:0]    src_i,
  input  logic                   engine_done_i,
  output logic                   resp_valid_o,
  output logic [31:0]            resp_data_o,
  output logic [LOG_CONTEXT-1:0] pointer_context_o,
  output logic [LOG_CONTEXT-1:0] running_context_o,
  output logic                   full_context_o,
  output logic                   is_critical_o,
  output logic [ID_WIDTH-1:0]    owner_o,
  output logic                   engine_start_o,
  output logic                   true_done_o,
  output logic                   busy_o
);

  localparam int unsigned CNT_W = $clog2(N_CONTEXT + 1);

  cxt_sched_state_t      state_q, state_d;
  logic [CNT_W-1:0]      n_occ_q, n_occ_d, n_occ_trig;
  logic                  lock_q, lock_d;
  logic [ID_WIDTH-1:0]   owner_q, owner_d;
  cxt_resp_t             resp_q, resp_d;
  logic                  start_q, start_d;
  logic                  tdone_q, tdone_d;
  logic                  full_q, full_d;
  logic                  busy_q, busy_d;

  logic                  trig_ok, lock_after_trig, full_after_trig, grant, done_ev;
  logic [LOG_CONTEXT-1:0] pointer_q, running_q, ptr_after_trig;

  hwpe_ctrl_cxt_ring_ptr #(
    .N (N_CONTEXT),
    .W (LOG_CONTEXT)
  ) i_pointer_ptr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (clear_i),
    .inc_i   (trig_ok),
    .ptr_o   (pointer_q)
  );

  hwpe_ctrl_cxt_ring_ptr #(
    .N (N_CONTEXT),
    .W (LOG_CONTEXT)
  ) i_running_ptr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (clear_i),
    .inc_i   (done_ev),
    .ptr_o   (running_q)
  );

  // Trigger is resolved before acquire so a same-cycle acquire sees its effect.
  always_comb begin
    trig_ok         = trigger_i && lock_q && (src_i == owner_q);
    n_occ_trig      = trig_ok ? (n_occ_q + CNT_W'(1)) : n_occ_q;
    lock_after_trig = lock_q && !trig_ok;
    full_after_trig = (n_occ_trig == CNT_W'(N_CONTEXT));
    grant           = acquire_i && !lock_after_trig && !full_after_trig;
    done_ev         = (state_q == CXT_RUN) && engine_done_i;
    ptr_after_trig  = trig_ok ? LOG_CONTEXT'(cxt_wrap_inc(32'(pointer_q), N_CONTEXT))
                              : pointer_q;
  end

  always_comb begin
    state_d = state_q;
    n_occ_d = n_occ_q;
    lock_d  = lock_q;
    owner_d = owner_q;
    resp_d  = '0;

    resp_d.valid = acquire_i;
    if (acquire_i) begin
      if (lock_after_trig) begin
        resp_d.data = 32'(CXT_RESP_ANOTHER_PE_OFFLOADING);
      end else if (full_after_trig) begin
        resp_d.data = 32'(CXT_RESP_ALL_CXT_BUSY);
      end else begin
        resp_d.data = 32'(ptr_after_trig);
      end
    end

    lock_d = grant || lock_after_trig;
    if (grant) begin
      owner_d = src_i;
    end else if (trig_ok) begin
      owner_d = '0;
    end

    unique case ({trig_ok, done_ev})
      2'b10:   n_occ_d = n_occ_q + CNT_W'(1);
      2'b01:   n_occ_d = n_occ_q - CNT_W'(1);
      default: n_occ_d = n_occ_q;
    endcase

    // In DONE the count already reflects the retired job.
    case (state_q)
      CXT_IDLE:  if (n_occ_q != '0) state_d = CXT_START;
      CXT_START: state_d = CXT_RUN;
      CXT_RUN:   if (engine_done_i) state_d = CXT_DONE;
      CXT_DONE:  state_d = (n_occ_q != '0) ? CXT_START : CXT_IDLE;
      default:   state_d = CXT_IDLE;
    endcase

    if (clear_i) begin
      state_d = CXT_IDLE;
      n_occ_d = '0;
      lock_d  = 1'b0;
      owner_d = '0;
      resp_d  = '0;
    end

    start_d = (state_d == CXT_START);
    tdone_d = (state_d == CXT_DONE);
    full_d  = (n_occ_d == CNT_W'(N_CONTEXT));
    busy_d  = (n_occ_d != '0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= CXT_IDLE;
      n_occ_q <= '0;
      lock_q  <= 1'b0;
      owner_q <= '0;
      resp_q  <= '0;
      start_q <= 1'b0;
      tdone_q <= 1'b0;
      full_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_occ_q <= n_occ_d;
      lock_q  <= lock_d;
      owner_q <= owner_d;
      resp_q  <= resp_d;
      start_q <= start_d;
      tdone_q <= tdone_d;
      full_q  <= full_d;
      busy_q  <= busy_d;
    end
  end

  assign resp_valid_o      = resp_q.valid;
  assign resp_data_o       = resp_q.data;
  assign pointer_context_o = pointer_q;
  assign running_context_o = running_q;
  assign full_context_o    = full_q;
  assign is_critical_o     = lock_q;
  assign owner_o           = owner_q;
  assign engine_start_o    = start_q;
  assign true_done_o       = tdone_q;
  assign busy_o            = busy_q;

endmodule

// File: tb/tb_hwpe_ctrl_cxt_sched.sv
// Bench for hwpe_ctrl_cxt_sched: directed scenarios plus randomized traffic
// checked against a job-queue reference model.
module tb_hwpe_ctrl_cxt_sched;

  localparam int unsigned N  = 2;
  localparam int unsigned IW = 16;
  localparam int unsigned LC = 1;

  localparam int PH_IDLE  = 0;
  localparam int PH_START = 1;
  localparam int PH_RUN   = 2;
  localparam int PH_DONE  = 3;

  logic          clk_i = 1'b0;
  logic          rst_i, clear_i, acquire_i, trigger_i, engine_done_i;
  logic [IW-1:0] src_i;
  logic          resp_valid_o;
  logic [31:0]   resp_data_o;
  logic [LC-1:0] pointer_context_o, running_context_o;
  logic          full_context_o, is_critical_o;
  logic [IW-1:0] owner_o;
  logic          engine_start_o, true_done_o, busy_o;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: jobs holds the context index of every triggered, unfinished job.
  int          m_jobs[$];
  int          m_ptr, m_run, m_owner, m_phase;
  bit          m_lock, m_resp_v, m_start, m_tdone;
  logic [31:0] m_resp_d;

  hwpe_ctrl_cxt_sched #(
    .N_CONTEXT (N),
    .ID_WIDTH  (IW)
  ) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .clear_i           (clear_i),
    .acquire_i         (acquire_i),
    .trigger_i         (trigger_i),
    .src_i             (src_i),
    .engine_done_i     (engine_done_i),
    .resp_valid_o      (resp_valid_o),
    .resp_data_o       (resp_data_o),
    .pointer_context_o (pointer_context_o),
    .running_context_o (running_context_o),
    .full_context_o    (full_context_o),
    .is_critical_o     (is_critical_o),
    .owner_o           (owner_o),
    .engine_start_o    (engine_start_o),
    .true_done_o       (true_done_o),
    .busy_o            (busy_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic void model_reset();
    m_jobs.delete();
    m_ptr = 0; m_run = 0; m_owner = 0; m_phase = PH_IDLE;
    m_lock = 0; m_resp_v = 0; m_start = 0; m_tdone = 0; m_resp_d = '0;
  endfunction

  function automatic void model_edge(bit acq, bit trg, int src, bit done, bit clr);
    int occ_before;
    bit trig_ok;
    if (clr) begin
      model_reset();
      return;
    end
    occ_before = m_jobs.size();
    trig_ok = trg && m_lock && (src == m_owner);
    if (trig_ok) begin
      m_lock = 0;
      m_owner = 0;
      m_jobs.push_back(m_ptr);
      m_ptr = (m_ptr + 1) % N;
    end
    m_resp_v = acq;
    m_resp_d = '0;
    if (acq) begin
      if (m_lock) m_resp_d = 32'hFFFF_FFFE;
      else if (m_jobs.size() == N) m_resp_d = 32'hFFFF_FFFF;
      else begin
        m_resp_d = 32'(m_ptr);
        m_lock = 1;
        m_owner = src;
      end
    end
    case (m_phase)
      PH_IDLE:  if (occ_before > 0) m_phase = PH_START;
      PH_START: m_phase = PH_RUN;
      PH_RUN:   if (done) begin
        m_phase = PH_DONE;
        void'(m_jobs.pop_front());
        m_run = (m_run + 1) % N;
      end
      default:  m_phase = (occ_before > 0) ? PH_START : PH_IDLE;
    endcase
    m_start = (m_phase == PH_START);
    m_tdone = (m_phase == PH_DONE);
  endfunction

  task automatic step(input bit acq, input bit trg, input int src, input bit done, input bit clr);
    acquire_i = acq; trigger_i = trg; src_i = IW'(src);
    engine_done_i = done; clear_i = clr;
    @(posedge clk_i);
    model_edge(acq, trg, src, done, clr);
    #1;
    acquire_i = 0; trigger_i = 0; engine_done_i = 0; clear_i = 0;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({resp_valid_o, resp_data_o, pointer_context_o, running_context_o, full_context_o,
         is_critical_o, owner_o, engine_start_o, true_done_o, busy_o} !== '0)
      $display("FAIL reset_outputs: got resp=%b/%h ptr=%0d run=%0d full=%b crit=%b own=%0d st=%b td=%b busy=%b, want all 0",
               resp_valid_o, resp_data_o, pointer_context_o, running_context_o, full_context_o,
               is_critical_o, owner_o, engine_start_o, true_done_o, busy_o);
    else n_pass++;
  endtask

  task automatic test_acquire();
    step(1, 0, 3, 0, 0);
    n_checks++;
    if (resp_valid_o !== 1'b1 || resp_data_o !== 32'h0)
      $display("FAIL acq_grant: got v=%b d=%h want v=1 d=00000000", resp_valid_o, resp_data_o);
    else n_pass++;
    n_checks++;
    if (is_critical_o !== 1'b1 || owner_o !== 16'd3)
      $display("FAIL acq_lock: got crit=%b owner=%0d want crit=1 owner=3", is_critical_o, owner_o);
    else n_pass++;
    step(0, 0, 0, 0, 0);
    n_checks++;
    if (resp_valid_o !== 1'b0)
      $display("FAIL acq_pulse: got v=%b want 0", resp_valid_o);
    else n_pass++;
  endtask

  task automatic test_lock();
    step(1, 0, 5, 0, 0);
    n_checks++;
    if (resp_valid_o !== 1'b1 || resp_data_o !== 32'hFFFF_FFFE)
      $display("FAIL lock_resp: got v=%b d=%h want v=1 d=fffffffe", resp_valid_o, resp_data_o);
    else n_pass++;
    step(0, 1, 5, 0, 0);
    n_checks++;
    if (pointer_context_o !== 1'b0 || is_critical_o !== 1'b1 || busy_o !== 1'b0)
      $display("FAIL lock_foreign_trig: got ptr=%0d crit=%b busy=%b want 0/1/0",
               pointer_context_o, is_critical_o, busy_o);
    else n_pass++;
    step(0, 1, 3, 0, 0);
    n_checks++;
    if (pointer_context_o !== 1'b1 || is_critical_o !== 1'b0 || busy_o !== 1'b1 || engine_start_o !== 1'b0)
      $display("FAIL lock_owner_trig: got ptr=%0d crit=%b busy=%b st=%b want 1/0/1/0",
               pointer_context_o, is_critical_o, busy_o, engine_start_o);
    else n_pass++;
    step(0, 0, 0, 0, 0);
    n_checks++;
    if (engine_start_o !== 1'b1)
      $display("FAIL lock_start: got st=%b want 1", engine_start_o);
    else n_pass++;
    step(0, 0, 0, 0, 0);
    n_checks++;
    if (engine_start_o !== 1'b0)
      $display("FAIL lock_start_pulse: got st=%b want 0", engine_start_o);
    else n_pass++;
  endtask

  task automatic test_full();
    step(1, 0, 3, 0, 0);
    n_checks++;
    if (resp_data_o !== 32'h1)
      $display("FAIL full_grant2: got d=%h want 00000001", resp_data_o);
    else n_pass++;
    step(0, 1, 3, 0, 0);
    step(1, 0, 7, 0, 0);
    n_checks++;
    if (resp_valid_o !== 1'b1 || resp_data_o !== 32'hFFFF_FFFF || full_context_o !== 1'b1)
      $display("FAIL full_refuse: got v=%b d=%h full=%b want 1/ffffffff/1",
               resp_valid_o, resp_data_o, full_context_o);
    else n_pass++;
    step(0, 0, 0, 1, 0);
    n_checks++;
    if (true_done_o !== 1'b1 || running_context_o !== 1'b1 || full_context_o !== 1'b0)
      $display("FAIL full_done: got td=%b run=%0d full=%b want 1/1/0",
               true_done_o, running_context_o, full_context_o);
    else n_pass++;
    step(0, 0, 0, 0, 0);
    n_checks++;
    if (engine_start_o !== 1'b1 || true_done_o !== 1'b0)
      $display("FAIL full_restart: got st=%b td=%b want 1/0", engine_start_o, true_done_o);
    else n_pass++;
    step(0, 0, 0, 0, 0);
  endtask

  task automatic test_trig_done_same();
    step(1, 0, 4, 0, 0);
    n_checks++;
    if (resp_data_o !== 32'h0 || is_critical_o !== 1'b1)
      $display("FAIL td_grant: got d=%h crit=%b want 00000000/1", resp_data_o, is_critical_o);
    else n_pass++;
    step(0, 1, 4, 1, 0);
    n_checks++;
    if (busy_o !== 1'b1 || full_context_o !== 1'b0 || pointer_context_o !== 1'b1 ||
        running_context_o !== 1'b0 || true_done_o !== 1'b1)
      $display("FAIL td_same_cycle: got busy=%b full=%b ptr=%0d run=%0d td=%b want 1/0/1/0/1",
               busy_o, full_context_o, pointer_context_o, running_context_o, true_done_o);
    else n_pass++;
    step(0, 0, 0, 0, 0);
    n_checks++;
    if (engine_start_o !== 1'b1)
      $display("FAIL td_restart: got st=%b want 1", engine_start_o);
    else n_pass++;
    step(0, 0, 0, 0, 0);
  endtask

  task automatic test_acq_trig_same();
    step(1, 0, 9, 0, 0);
    n_checks++;
    if (resp_data_o !== 32'h1)
      $display("FAIL at_grant: got d=%h want 00000001", resp_data_o);
    else n_pass++;
    step(1, 1, 9, 0, 0);
    n_checks++;
    if (resp_valid_o !== 1'b1 || resp_data_o !== 32'hFFFF_FFFF || full_context_o !== 1'b1 ||
        is_critical_o !== 1'b0 || pointer_context_o !== 1'b0)
      $display("FAIL at_same_cycle: got v=%b d=%h full=%b crit=%b ptr=%0d want 1/ffffffff/1/0/0",
               resp_valid_o, resp_data_o, full_context_o, is_critical_o, pointer_context_o);
    else n_pass++;
  endtask

  task automatic test_clear();
    step(0, 0, 0, 0, 1);
    n_checks++;
    if ({resp_valid_o, resp_data_o, pointer_context_o, running_context_o, full_context_o,
         is_critical_o, owner_o, engine_start_o, true_done_o, busy_o} !== '0)
      $display("FAIL clear_outputs: got ptr=%0d run=%0d full=%b crit=%b busy=%b, want all 0",
               pointer_context_o, running_context_o, full_context_o, is_critical_o, busy_o);
    else n_pass++;
    step(0, 0, 0, 1, 0);
    n_checks++;
    if (true_done_o !== 1'b0 || engine_start_o !== 1'b0 || busy_o !== 1'b0)
      $display("FAIL clear_late_done: got td=%b st=%b busy=%b want 0/0/0",
               true_done_o, engine_start_o, busy_o);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    step(1, 0, 2, 0, 0);
    step(0, 1, 2, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    #2 rst_i = 1'b1;
    #2;
    n_checks++;
    if ({resp_valid_o, resp_data_o, pointer_context_o, running_context_o, full_context_o,
         is_critical_o, owner_o, engine_start_o, true_done_o, busy_o} !== '0)
      $display("FAIL arst_outputs: got ptr=%0d run=%0d crit=%b busy=%b, want all 0",
               pointer_context_o, running_context_o, is_critical_o, busy_o);
    else n_pass++;
    rst_i = 1'b0;
    model_reset();
    step(0, 0, 0, 1, 0);
    n_checks++;
    if (true_done_o !== 1'b0 || busy_o !== 1'b0)
      $display("FAIL arst_late_done: got td=%b busy=%b want 0/0", true_done_o, busy_o);
    else n_pass++;
  endtask

  task automatic test_random(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      bit acq, trg, done, clr;
      int src;
      acq  = ($urandom_range(0, 3) == 0);
      trg  = ($urandom_range(0, 2) == 0);
      done = ($urandom_range(0, 3) == 0);
      clr  = ($urandom_range(0, 255) == 0);
      src  = (trg && $urandom_range(0, 1) == 0) ? m_owner : int'($urandom_range(1, 3));
      step(acq, trg, src, done, clr);
      n_checks++;
      if (resp_valid_o !== m_resp_v || (m_resp_v && resp_data_o !== m_resp_d))
        $display("FAIL rand_resp cyc %0d: got v=%b d=%h want v=%b d=%h",
                 i, resp_valid_o, resp_data_o, m_resp_v, m_resp_d);
      else n_pass++;
      n_checks++;
      if (pointer_context_o !== LC'(m_ptr) || running_context_o !== LC'(m_run))
        $display("FAIL rand_ptrs cyc %0d: got ptr=%0d run=%0d want ptr=%0d run=%0d",
                 i, pointer_context_o, running_context_o, m_ptr, m_run);
      else n_pass++;
      n_checks++;
      if (full_context_o !== (m_jobs.size() == N) || busy_o !== (m_jobs.size() != 0))
        $display("FAIL rand_occ cyc %0d: got full=%b busy=%b want occupancy %0d",
                 i, full_context_o, busy_o, m_jobs.size());
      else n_pass++;
      n_checks++;
      if (is_critical_o !== m_lock || owner_o !== IW'(m_owner))
        $display("FAIL rand_lock cyc %0d: got crit=%b owner=%0d want crit=%b owner=%0d",
                 i, is_critical_o, owner_o, m_lock, m_owner);
      else n_pass++;
      n_checks++;
      if (engine_start_o !== m_start || true_done_o !== m_tdone)
        $display("FAIL rand_engine cyc %0d: got st=%b td=%b want st=%b td=%b",
                 i, engine_start_o, true_done_o, m_start, m_tdone);
      else n_pass++;
    end
  endtask

  initial begin
    rst_i = 1'b1; clear_i = 0; acquire_i = 0; trigger_i = 0;
    engine_done_i = 0; src_i = '0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    test_reset();
    test_acquire();
    test_lock();
    test_full();
    test_trig_done_same();
    test_acq_trig_same();
    test_clear();
    test_async_reset();
    test_random(3000);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
